adder_operand_loader: RTL and testbench

- Upstream front-end of the four-operand adder.
- Accepts operands one word at a time over a valid/ready stream and stores them in order into slots A, B, C, D.
- Once D is stored, issues a single-cycle go pulse to the adder controller.
- Holds A..D stable until the controller's output_enable (done_in) shows that the batch has completed, then re-opens the stream.

---
 rtl/adder_pkg.sv | 19 +
 rtl/timeout_counter.sv | 30 +++
 rtl/adder_operand_loader.sv | 145 ++++++++++++++
 tb/tb_adder_operand_loader.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// rtl/adder_pkg.sv - shared state, slot and default constants for the adder operand loader
package adder_pkg;

  typedef enum logic [1:0] {
    COLLECT  = 2'd0,
    LAUNCH   = 2'd1,
    WAIT_CLR = 2'd2,
    WAIT_SET = 2'd3
  } state_t;

  localparam logic [1:0] SLOT_A = 2'd0;
  localparam logic [1:0] SLOT_B = 2'd1;
  localparam logic [1:0] SLOT_C = 2'd2;
  localparam logic [1:0] SLOT_D = 2'd3;

  localparam int DEFAULT_WIDTH   = 8;
  localparam int DEFAULT_TIMEOUT = 16;

endpackage

// File: rtl/timeout_counter.sv
// rtl/timeout_counter.sv - wait-cycle counter that flags when TIMEOUT cycles have been spent
module timeout_counter #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] count;

  // Holds at the terminal value so expired stays asserted until cleared.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + CW'(1);
    end
  end

  assign expired = (count == LAST);

endmodule

// File: rtl/adder_operand_loader.sv
// rtl/adder_operand_loader.sv - collects four operands from a stream, launches the adder and waits for completion
module adder_operand_loader
  import adder_pkg::*;
#(
  parameter int WIDTH   = DEFAULT_WIDTH,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  input  logic             done_in,
  output logic             go,
  output logic [WIDTH-1:0] a_out,
  output logic [WIDTH-1:0] b_out,
  output logic [WIDTH-1:0] c_out,
  output logic [WIDTH-1:0] d_out,
  output logic             busy,
  output logic             batch_done,
  output logic             err
);

  state_t           state, state_nxt;
  logic [1:0]       idx, idx_nxt;
  logic             in_ready_nxt, go_nxt, busy_nxt, batch_done_nxt, err_nxt;
  logic [WIDTH-1:0] a_nxt, b_nxt, c_nxt, d_nxt;
  logic             wait_en, wait_clear, expired;

  assign wait_en    = (state == WAIT_CLR) || (state == WAIT_SET);
  assign wait_clear = clr || (state == LAUNCH);

  timeout_counter #(.TIMEOUT(TIMEOUT)) u_wait_cnt (
    .clk     (clk),
    .rst     (rst),
    .clear   (wait_clear),
    .enable  (wait_en),
    .expired (expired)
  );

  always_comb begin
    state_nxt      = state;
    idx_nxt        = idx;
    in_ready_nxt   = in_ready;
    go_nxt         = 1'b0;
    busy_nxt       = busy;
    batch_done_nxt = 1'b0;
    err_nxt        = err;
    a_nxt          = a_out;
    b_nxt          = b_out;
    c_nxt          = c_out;
    d_nxt          = d_out;

    if (clr) begin
      state_nxt    = COLLECT;
      idx_nxt      = SLOT_A;
      in_ready_nxt = 1'b1;
      busy_nxt     = 1'b0;
      err_nxt      = 1'b0;
      a_nxt        = '0;
      b_nxt        = '0;
      c_nxt        = '0;
      d_nxt        = '0;
    end else begin
      case (state)
        COLLECT: begin
          in_ready_nxt = 1'b1;
          busy_nxt     = 1'b0;
          if (in_valid && in_ready) begin
            case (idx)
              SLOT_A: a_nxt = in_data;
              SLOT_B: b_nxt = in_data;
              SLOT_C: c_nxt = in_data;
              SLOT_D: d_nxt = in_data;
            endcase
            if (idx == SLOT_D) begin
              state_nxt    = LAUNCH;
              idx_nxt      = SLOT_A;
              in_ready_nxt = 1'b0;
              busy_nxt     = 1'b1;
              go_nxt       = 1'b1;
            end else begin
              idx_nxt = idx + 2'd1;
            end
          end
        end
        LAUNCH: state_nxt = WAIT_CLR;
        // The batch cannot complete from WAIT_CLR, so an expired budget wins here.
        WAIT_CLR: begin
          if (expired) begin
            state_nxt    = COLLECT;
            in_ready_nxt = 1'b1;
            busy_nxt     = 1'b0;
            err_nxt      = 1'b1;
          end else if (!done_in) begin
            state_nxt = WAIT_SET;
          end
        end
        WAIT_SET: begin
          if (done_in) begin
            state_nxt      = COLLECT;
            in_ready_nxt   = 1'b1;
            busy_nxt       = 1'b0;
            batch_done_nxt = 1'b1;
          end else if (expired) begin
            state_nxt    = COLLECT;
            in_ready_nxt = 1'b1;
            busy_nxt     = 1'b0;
            err_nxt      = 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= COLLECT;
      idx        <= SLOT_A;
      in_ready   <= 1'b0;
      go         <= 1'b0;
      busy       <= 1'b0;
      batch_done <= 1'b0;
      err        <= 1'b0;
      a_out      <= '0;
      b_out      <= '0;
      c_out      <= '0;
      d_out      <= '0;
    end else begin
      state      <= state_nxt;
      idx        <= idx_nxt;
      in_ready   <= in_ready_nxt;
      go         <= go_nxt;
      busy       <= busy_nxt;
      batch_done <= batch_done_nxt;
      err        <= err_nxt;
      a_out      <= a_nxt;
      b_out      <= b_nxt;
      c_out      <= c_nxt;
      d_out      <= d_nxt;
    end
  end

endmodule

// File: tb/tb_adder_operand_loader.sv
// tb/tb_adder_operand_loader.sv - self-checking bench for adder_operand_loader
module tb_adder_operand_loader;

  localparam int WIDTH   = 8;
  localparam int TIMEOUT = 16;

  logic             clk = 1'b0;
  logic             rst, clr, in_valid, done_in;
  logic [WIDTH-1:0] in_data;
  logic             in_ready, go, busy, batch_done, err;
  logic [WIDTH-1:0] a_out, b_out, c_out, d_out;

  int checks = 0;
  int errors = 0;

  logic [WIDTH-1:0] exp_slot [4];
  logic             exp_err;

  adder_operand_loader #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .rst        (rst),
    .clr        (clr),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .done_in    (done_in),
    .go         (go),
    .a_out      (a_out),
    .b_out      (b_out),
    .c_out      (c_out),
    .d_out      (d_out),
    .busy       (busy),
    .batch_done (batch_done),
    .err        (err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_word(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_slots(input string tag);
    check_word({tag, "_a"}, a_out, exp_slot[0]);
    check_word({tag, "_b"}, b_out, exp_slot[1]);
    check_word({tag, "_c"}, c_out, exp_slot[2]);
    check_word({tag, "_d"}, d_out, exp_slot[3]);
  endtask

  task automatic check_reset(input string tag);
    for (int i = 0; i < 4; i++) exp_slot[i] = '0;
    exp_err = 1'b0;
    check_slots(tag);
    check_bit({tag, "_ready"}, in_ready, 1'b0);
    check_bit({tag, "_go"}, go, 1'b0);
    check_bit({tag, "_busy"}, busy, 1'b0);
    check_bit({tag, "_bd"}, batch_done, 1'b0);
    check_bit({tag, "_err"}, err, 1'b0);
  endtask

  // Controller model: done_in high for hi0 cycles after go, low for lo cycles, then high.
  function automatic logic sched(input int j, input int hi0, input int lo);
    return (j <= hi0) ? 1'b1 : ((j <= hi0 + lo) ? 1'b0 : 1'b1);
  endfunction

  // Source: offers words in order; valid follows pat for pat_len cycles, then random or steady.
  task automatic feed(input logic [WIDTH-1:0] w0, input logic [WIDTH-1:0] w1,
                      input logic [WIDTH-1:0] w2, input logic [WIDTH-1:0] w3,
                      input logic [15:0] pat, input int pat_len, input int rand_gaps,
                      input int n_stop);
    logic [WIDTH-1:0] words [4];
    logic v;
    int n;
    int k;
    words[0] = w0; words[1] = w1; words[2] = w2; words[3] = w3;
    n = 0;
    k = 0;
    while (n < n_stop && k < 64) begin
      if (k < pat_len) v = pat[k];
      else if (rand_gaps != 0 && k < 16) v = ($urandom_range(0, 3) != 0);
      else v = 1'b1;
      in_valid = v;
      in_data  = v ? words[n] : WIDTH'($urandom);
      done_in  = 1'($urandom_range(0, 1));
      step();
      if (v) begin
        exp_slot[n] = words[n];
        n++;
      end
      check_slots("feed");
      check_bit("feed_go", go, v && (n == 4));
      check_bit("feed_ready", in_ready, n < 4);
      check_bit("feed_busy", busy, n == 4);
      check_bit("feed_bd", batch_done, 1'b0);
      check_bit("feed_err", err, exp_err);
      k++;
    end
    in_valid = 1'b0;
    check_bit("feed_count", n == n_stop, 1'b1);
  endtask

  // After go: the batch has TIMEOUT wait cycles to see done_in fall and then rise again.
  task automatic wait_phase(input int hi0, input int lo, input logic hold_valid,
                            input logic [WIDTH-1:0] hold_data, input int stop_j);
    int jl, jh, end_j, last;
    logic timed_out;
    jl = -1;
    jh = -1;
    for (int j = 2; j <= TIMEOUT + 1; j++) begin
      if (jl < 0 && !sched(j, hi0, lo)) jl = j;
      else if (jl >= 0 && jh < 0 && sched(j, hi0, lo)) jh = j;
    end
    timed_out = (jh < 0);
    end_j     = timed_out ? TIMEOUT + 1 : jh;
    last      = (stop_j != 0 && stop_j < end_j) ? stop_j : end_j;
    for (int j = 1; j <= last; j++) begin
      done_in  = sched(j, hi0, lo);
      in_valid = hold_valid;
      in_data  = hold_data;
      step();
      check_slots("wait");
      check_bit("wait_go", go, 1'b0);
      check_bit("wait_bd", batch_done, (j == end_j) && !timed_out);
      check_bit("wait_ready", in_ready, j == end_j);
      check_bit("wait_busy", busy, j != end_j);
      if (j == end_j && timed_out) exp_err = 1'b1;
      check_bit("wait_err", err, exp_err);
    end
  endtask

  task automatic do_clr();
    clr      = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'hCC;
    step();
    clr      = 1'b0;
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) exp_slot[i] = '0;
    exp_err = 1'b0;
    check_slots("clr");
    check_bit("clr_ready", in_ready, 1'b1);
    check_bit("clr_go", go, 1'b0);
    check_bit("clr_busy", busy, 1'b0);
    check_bit("clr_bd", batch_done, 1'b0);
    check_bit("clr_err", err, 1'b0);
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; in_valid = 1'b0; in_data = '0; done_in = 1'b1;
    exp_err = 1'b0;
    for (int i = 0; i < 4; i++) exp_slot[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset("reset");
    rst = 1'b0;
    #1;
    check_bit("ready_before_edge", in_ready, 1'b0);
    step();
    check_bit("ready_after_edge", in_ready, 1'b1);

    // Basic batch, done_in stale high at launch.
    feed(8'h11, 8'h22, 8'h33, 8'h44, 16'h0, 0, 0, 4);
    wait_phase(1, 6, 1'b0, 8'h00, 0);

    // Gapped source, then backpressure with 0x99 held through the wait.
    feed(8'h05, 8'h06, 8'h07, 8'h08, 16'b1011001, 7, 0, 4);
    wait_phase(0, 3, 1'b1, 8'h99, 0);
    feed(8'h99, 8'h12, 8'h34, 8'h56, 16'h0, 0, 0, 4);
    wait_phase(2, 4, 1'b0, 8'h00, 0);

    // Timeout with done_in stuck high, then clr clears err.
    feed(8'hE1, 8'hE2, 8'hE3, 8'hE4, 16'h0, 0, 0, 4);
    wait_phase(100, 0, 1'b0, 8'h00, 0);
    do_clr();

    // clr mid-collection, refill from slot A.
    feed(8'hAA, 8'hBB, 8'h00, 8'h00, 16'h0, 0, 0, 2);
    do_clr();
    feed(8'hC1, 8'hC2, 8'hC3, 8'hC4, 16'h0, 0, 0, 4);
    wait_phase(1, 2, 1'b0, 8'h00, 0);

    // Reset while in WAIT_SET.
    feed(8'hD1, 8'hD2, 8'hD3, 8'hD4, 16'h0, 0, 0, 4);
    wait_phase(1, 30, 1'b0, 8'h00, 4);
    #2;
    rst     = 1'b1;
    done_in = 1'b1;
    #1;
    check_reset("rst_async");
    repeat (2) begin
      step();
      check_reset("rst_hold");
    end
    rst = 1'b0;
    #1;
    check_bit("rst_rel_ready", in_ready, 1'b0);
    step();
    check_bit("rst_rel_ready_edge", in_ready, 1'b1);
    check_bit("rst_rel_bd", batch_done, 1'b0);

    // Randomized batches: random words, gaps, controller latency and timeouts.
    for (int b = 0; b < 10; b++) begin
      feed(WIDTH'($urandom), WIDTH'($urandom), WIDTH'($urandom), WIDTH'($urandom),
           16'h0, 0, 1, 4);
      wait_phase($urandom_range(0, 3), $urandom_range(1, 20),
                 1'($urandom_range(0, 1)), WIDTH'($urandom), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
